// File: rtl/host_cmd_ctrl.sv
// Host command sequencer: pops opcode/address/data bytes from the bridge RX FIFO,
// runs one register-bus transaction per frame and serves status/read data as a FIFO read port.
module host_cmd_ctrl #(
  parameter int         DATA_BYTES = 4,
  parameter int         TIMEOUT    = 256,
  parameter logic [7:0] ACK_CODE   = 8'hAA,
  parameter logic [7:0] NAK_CODE   = 8'hEE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    rx_fifo_rd_en,
  input  logic [7:0]              rx_fifo_dout,
  input  logic                    rx_fifo_empty,
  input  logic                    tx_fifo_rd_en,
  output logic [7:0]              tx_fifo_din,
  output logic                    tx_fifo_empty,
  output logic [7:0]              reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_wr,
  output logic                    reg_rd,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  input  logic                    reg_ack,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = $clog2(DATA_BYTES + 2);
  localparam int BW = 8 * (DATA_BYTES + 1);

  localparam logic [7:0]    OP_WR       = 8'h57;
  localparam logic [7:0]    OP_RD       = 8'h52;
  localparam logic [IW-1:0] LAST_IDX    = IW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RD_RESP_LEN = CW'(DATA_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_BUS  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  // state_q is the observable FSM state for checkers.
  state_t state_q, state_d;

  logic          rx_vld;
  logic          is_rd;
  logic [IW-1:0] byte_idx;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] resp_buf;
  logic [CW-1:0] resp_cnt;

  logic fetch_st, set_wr, set_rd, bad_op, latch_addr, latch_data;
  logic start_bus, bus_ack, bus_tmo, tx_pop;

  // Handshake: a pop is requested for one cycle and its byte is consumed the
  // following cycle (rx_vld); no new pop is issued while one is outstanding.
  assign fetch_st      = (state_q == S_OP) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_fifo_rd_en = enable && !reset && !rx_fifo_empty && fetch_st && !rx_vld;
  assign tx_fifo_empty = (resp_cnt == '0);
  assign tx_pop        = tx_fifo_rd_en && !tx_fifo_empty;
  assign busy          = (state_q != S_IDLE) || !tx_fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    set_wr     = 1'b0;
    set_rd     = 1'b0;
    bad_op     = 1'b0;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    start_bus  = 1'b0;
    bus_ack    = 1'b0;
    bus_tmo    = 1'b0;
    case (state_q)
      S_IDLE: if (enable && tx_fifo_empty) state_d = S_OP;
      S_OP: begin
        if (!enable) state_d = S_IDLE;
        else if (rx_vld) begin
          if (rx_fifo_dout == OP_WR) begin
            set_wr  = 1'b1;
            state_d = S_ADDR;
          end else if (rx_fifo_dout == OP_RD) begin
            set_rd  = 1'b1;
            state_d = S_ADDR;
          end else begin
            bad_op  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (!enable) state_d = S_IDLE;
        else if (rx_vld) begin
          latch_addr = 1'b1;
          if (is_rd) begin
            start_bus = 1'b1;
            state_d   = S_BUS;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (!enable) state_d = S_IDLE;
        else if (rx_vld) begin
          latch_data = 1'b1;
          if (byte_idx == LAST_IDX) begin
            start_bus = 1'b1;
            state_d   = S_BUS;
          end
        end
      end
      // An ack in the same cycle as the timeout wins.
      S_BUS: begin
        if (reg_ack) begin
          bus_ack = 1'b1;
          state_d = S_RESP;
        end else if (tmo_cnt == TMO_MAX) begin
          bus_tmo = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  if (tx_fifo_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_vld      <= 1'b0;
      is_rd       <= 1'b0;
      byte_idx    <= '0;
      tmo_cnt     <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      err_cnt     <= '0;
      resp_buf    <= '0;
      resp_cnt    <= '0;
      tx_fifo_din <= '0;
    end else begin
      rx_vld <= rx_fifo_rd_en;
      if (set_wr || set_rd) begin
        is_rd    <= set_rd;
        byte_idx <= '0;
      end
      if (latch_addr) reg_addr <= rx_fifo_dout;
      if (latch_data) begin
        for (int i = 0; i < DATA_BYTES; i++)
          if (byte_idx == IW'(i)) reg_wdata[8*i +: 8] <= rx_fifo_dout;
        byte_idx <= byte_idx + 1'b1;
      end
      if (start_bus) begin
        reg_wr  <= !is_rd;
        reg_rd  <= is_rd;
        tmo_cnt <= '0;
      end else if (state_q == S_BUS) begin
        if (bus_ack || bus_tmo) begin
          reg_wr <= 1'b0;
          reg_rd <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
      if ((bad_op || bus_tmo) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
      // Loads only happen while the buffer is empty, so they never meet a pop.
      if (bad_op || bus_tmo) begin
        resp_buf <= BW'(NAK_CODE);
        resp_cnt <= CW'(1);
      end else if (bus_ack) begin
        resp_buf <= is_rd ? {reg_rdata, ACK_CODE} : BW'(ACK_CODE);
        resp_cnt <= is_rd ? RD_RESP_LEN : CW'(1);
      end else if (tx_pop) begin
        tx_fifo_din <= resp_buf[7:0];
        resp_buf    <= resp_buf >> 8;
        resp_cnt    <= resp_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Directed bench for host_cmd_ctrl: RX FIFO model, register-bus responder driven per test,
// response bytes pulled through the TX read port and compared against hand-computed values.
module tb_host_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rx_fifo_rd_en;
  logic [7:0]  rx_fifo_dout;
  logic        rx_fifo_empty;
  logic        tx_fifo_rd_en;
  logic [7:0]  tx_fifo_din;
  logic        tx_fifo_empty;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        busy;
  logic [7:0]  err_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [7:0] rx_mem [0:63];
  int rx_wp = 0;
  int rx_rp = 0;

  host_cmd_ctrl #(
    .DATA_BYTES(4), .TIMEOUT(256), .ACK_CODE(8'hAA), .NAK_CODE(8'hEE)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_dout(rx_fifo_dout), .rx_fifo_empty(rx_fifo_empty),
    .tx_fifo_rd_en(tx_fifo_rd_en), .tx_fifo_din(tx_fifo_din), .tx_fifo_empty(tx_fifo_empty),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy), .err_cnt(err_cnt)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // RX FIFO model: non-FWFT, data appears the cycle after a pop.
  assign rx_fifo_empty = (rx_wp == rx_rp);
  always @(posedge clk) begin
    if (rx_fifo_rd_en && !rx_fifo_empty) begin
      rx_fifo_dout <= rx_mem[rx_rp[5:0]];
      rx_rp        <= rx_rp + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, got timeout want completion");
    $fatal(1);
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wp[5:0]] = b;
    rx_wp = rx_wp + 1;
  endtask

  task automatic apply_reset(input logic en);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; tx_fifo_rd_en = 1'b0; reg_ack = 1'b0;
    step(2);
    reset = 1'b0; enable = en;
  endtask

  task automatic wait_strobe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (reg_wr || reg_rd) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_resp(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!tx_fifo_empty) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack_once();
    reg_ack = 1'b1;
    step(1);
    reg_ack = 1'b0;
  endtask

  task automatic pop(output logic [7:0] b);
    tx_fifo_rd_en = 1'b1;
    step(1);
    tx_fifo_rd_en = 1'b0;
    b = tx_fifo_din;
  endtask

  // Tests
  task automatic test_reset();
    apply_reset(1'b0);
    vec_cnt++;
    if ({rx_fifo_rd_en, tx_fifo_empty, reg_wr, reg_rd, busy} !== 5'b01000) begin
      miss_cnt++;
      $display("FAIL reset_ctrl: got %b want 01000", {rx_fifo_rd_en, tx_fifo_empty, reg_wr, reg_rd, busy});
    end
    vec_cnt++;
    if ({tx_fifo_din, reg_addr, err_cnt, reg_wdata} !== 56'h0) begin
      miss_cnt++;
      $display("FAIL reset_data: got %h want 0", {tx_fifo_din, reg_addr, err_cnt, reg_wdata});
    end
  endtask

  task automatic test_write();
    bit seen;
    logic [7:0] b;
    apply_reset(1'b1);
    push(8'h57); push(8'h10); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    wait_strobe(seen);
    vec_cnt++;
    if (seen !== 1'b1 || reg_wr !== 1'b1 || reg_rd !== 1'b0) begin
      miss_cnt++;
      $display("FAIL wr_strobe: got seen=%b wr=%b rd=%b want 1 1 0", seen, reg_wr, reg_rd);
    end
    vec_cnt++;
    if (reg_addr !== 8'h10 || reg_wdata !== 32'h12345678) begin
      miss_cnt++;
      $display("FAIL wr_addr_data: got %h/%h want 10/12345678", reg_addr, reg_wdata);
    end
    vec_cnt++;
    if (tx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL wr_pre_ack_empty: got %b want 1", tx_fifo_empty);
    end
    ack_once();
    vec_cnt++;
    if (reg_wr !== 1'b0 || tx_fifo_empty !== 1'b0 || busy !== 1'b1) begin
      miss_cnt++;
      $display("FAIL wr_post_ack: got wr=%b empty=%b busy=%b want 0 0 1", reg_wr, tx_fifo_empty, busy);
    end
    pop(b);
    vec_cnt++;
    if (b !== 8'hAA || tx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL wr_resp: got %h empty=%b want aa empty=1", b, tx_fifo_empty);
    end
    // Pop while empty: output must hold, no underflow.
    pop(b);
    vec_cnt++;
    if (b !== 8'hAA || tx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL wr_underflow: got %h empty=%b want aa empty=1", b, tx_fifo_empty);
    end
  endtask

  task automatic test_read();
    bit seen;
    logic [7:0] b;
    logic [7:0] exp_b [5] = '{8'hAA, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
    apply_reset(1'b1);
    reg_rdata = 32'hCAFEBABE;
    push(8'h52); push(8'h20);
    wait_strobe(seen);
    vec_cnt++;
    if (seen !== 1'b1 || reg_rd !== 1'b1 || reg_wr !== 1'b0 || reg_addr !== 8'h20) begin
      miss_cnt++;
      $display("FAIL rd_strobe: got seen=%b rd=%b wr=%b addr=%h want 1 1 0 20", seen, reg_rd, reg_wr, reg_addr);
    end
    for (int k = 2; k <= 5; k++) begin
      step(1);
      vec_cnt++;
      if (reg_rd !== 1'b1) begin
        miss_cnt++;
        $display("FAIL rd_hold_%0d: got %b want 1", k, reg_rd);
      end
    end
    ack_once();
    vec_cnt++;
    if (reg_rd !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rd_drop: got %b want 0", reg_rd);
    end
    for (int k = 0; k < 5; k++) begin
      pop(b);
      vec_cnt++;
      if (b !== exp_b[k]) begin
        miss_cnt++;
        $display("FAIL rd_byte_%0d: got %h want %h", k, b, exp_b[k]);
      end
    end
    vec_cnt++;
    if (tx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL rd_drained: got %b want 1", tx_fifo_empty);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int cnt;
    logic [7:0] b;
    apply_reset(1'b1);
    push(8'h52); push(8'h30);
    wait_strobe(seen);
    cnt = 0;
    while (reg_rd === 1'b1 && cnt < 400) begin
      cnt++;
      step(1);
    end
    vec_cnt++;
    if (seen !== 1'b1 || cnt !== 256) begin
      miss_cnt++;
      $display("FAIL tmo_len: got seen=%b cycles=%0d want 1 256", seen, cnt);
    end
    vec_cnt++;
    if (tx_fifo_empty !== 1'b0 || err_cnt !== 8'd1) begin
      miss_cnt++;
      $display("FAIL tmo_status: got empty=%b err=%0d want 0 1", tx_fifo_empty, err_cnt);
    end
    pop(b);
    vec_cnt++;
    if (b !== 8'hEE || tx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL tmo_resp: got %h empty=%b want ee 1", b, tx_fifo_empty);
    end
  endtask

  task automatic test_resync();
    bit seen;
    logic [7:0] b;
    logic [7:0] exp_b [5] = '{8'hAA, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
    apply_reset(1'b1);
    reg_rdata = 32'h0BADF00D;
    push(8'h41); push(8'h52); push(8'h40);
    wait_resp(seen);
    pop(b);
    vec_cnt++;
    if (seen !== 1'b1 || b !== 8'hEE || err_cnt !== 8'd1) begin
      miss_cnt++;
      $display("FAIL sync_nak: got seen=%b %h err=%0d want 1 ee 1", seen, b, err_cnt);
    end
    wait_strobe(seen);
    vec_cnt++;
    if (seen !== 1'b1 || reg_rd !== 1'b1 || reg_addr !== 8'h40) begin
      miss_cnt++;
      $display("FAIL sync_read: got seen=%b rd=%b addr=%h want 1 1 40", seen, reg_rd, reg_addr);
    end
    ack_once();
    for (int k = 0; k < 5; k++) begin
      pop(b);
      vec_cnt++;
      if (b !== exp_b[k]) begin
        miss_cnt++;
        $display("FAIL sync_byte_%0d: got %h want %h", k, b, exp_b[k]);
      end
    end
  endtask

  task automatic test_abort();
    bit seen;
    logic [7:0] b;
    apply_reset(1'b1);
    push(8'h57); push(8'h10); push(8'h11); push(8'h22);
    step(12);
    vec_cnt++;
    if (busy !== 1'b1 || rx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL abort_midframe: got busy=%b rxempty=%b want 1 1", busy, rx_fifo_empty);
    end
    enable = 1'b0;
    step(1);
    vec_cnt++;
    if (busy !== 1'b0 || reg_wr !== 1'b0 || tx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL abort_idle: got busy=%b wr=%b empty=%b want 0 0 1", busy, reg_wr, tx_fifo_empty);
    end
    step(20);
    vec_cnt++;
    if (reg_wr !== 1'b0 || tx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL abort_quiet: got wr=%b empty=%b want 0 1", reg_wr, tx_fifo_empty);
    end
    enable = 1'b1;
    push(8'h57); push(8'h44); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_strobe(seen);
    vec_cnt++;
    if (seen !== 1'b1 || reg_wr !== 1'b1 || reg_addr !== 8'h44 || reg_wdata !== 32'h04030201) begin
      miss_cnt++;
      $display("FAIL abort_rewrite: got seen=%b wr=%b %h/%h want 1 1 44/04030201", seen, reg_wr, reg_addr, reg_wdata);
    end
    ack_once();
    pop(b);
    vec_cnt++;
    if (b !== 8'hAA) begin
      miss_cnt++;
      $display("FAIL abort_resp: got %h want aa", b);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [7:0] b;
    apply_reset(1'b1);
    push(8'h41);
    wait_resp(seen);
    pop(b);
    vec_cnt++;
    if (seen !== 1'b1 || b !== 8'hEE || err_cnt !== 8'd1) begin
      miss_cnt++;
      $display("FAIL rst_pre_nak: got seen=%b %h err=%0d want 1 ee 1", seen, b, err_cnt);
    end
    push(8'h52); push(8'h60);
    wait_strobe(seen);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    enable = 1'b0;
    vec_cnt++;
    if (seen !== 1'b1 || reg_rd !== 1'b0 || tx_fifo_empty !== 1'b1 || err_cnt !== 8'd0 || busy !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rst_mid: got seen=%b rd=%b empty=%b err=%0d busy=%b want 1 0 1 0 0",
               seen, reg_rd, tx_fifo_empty, err_cnt, busy);
    end
    pop(b);
    vec_cnt++;
    if (b !== 8'h00 || tx_fifo_empty !== 1'b1) begin
      miss_cnt++;
      $display("FAIL rst_empty_pop: got %h empty=%b want 00 1", b, tx_fifo_empty);
    end
    step(10);
    vec_cnt++;
    if (reg_rd !== 1'b0 || reg_wr !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rst_no_strobe: got rd=%b wr=%b want 0 0", reg_rd, reg_wr);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tx_fifo_rd_en = 1'b0;
    reg_ack = 1'b0; reg_rdata = 32'h0;
    step(2);
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_resync();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
